// File: rtl/i2c_slave_responder_if.sv
// Open-drain I2C bus bundle between a master bench and the slave responder.
// The slave samples the resolved levels and drives pad enables.
interface i2c_slave_responder_if;
  logic scl_i;
  logic sda_i;
  logic slv_scl_pad_o;
  logic slv_scl_pad_oe;
  logic slv_sda_pad_o;
  logic slv_sda_pad_oe;

  modport slave (
    input  scl_i, sda_i,
    output slv_scl_pad_o, slv_scl_pad_oe, slv_sda_pad_o, slv_sda_pad_oe
  );

  modport master (
    output scl_i, sda_i,
    input  slv_scl_pad_o, slv_scl_pad_oe, slv_sda_pad_o, slv_sda_pad_oe
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target with one 7-bit address and a small byte-addressed register file.
// Writes set a pointer then store data; reads stream data from the pointer.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         MEM_DEPTH  = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  i2c_slave_responder_if.slave         bus,
  output logic                         busy,
  output logic                         wr_strobe,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [7:0]                   dbg_data
);
  localparam int PW = $clog2(MEM_DEPTH);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_PTR, WR_PTR_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    scl_sync, sda_sync;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    tx, tx_nxt;
  logic [PW-1:0] ptr, ptr_nxt, ptr_inc;
  logic          sda_oe, oe_nxt;
  logic          busy_nxt, strobe_nxt, rw, rw_nxt, mem_we;
  logic [7:0]    mem [MEM_DEPTH];

  logic scl_rise, scl_fall, start_det, stop_det, sda_s, shifting;

  // Stage boundary: two-flop synchronizers plus an edge-detect stage
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], bus.scl_i};
      sda_sync <= {sda_sync[1:0], bus.sda_i};
    end
  end

  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_sync[1] & ~scl_sync[2];
  assign scl_fall  = ~scl_sync[1] & scl_sync[2];
  assign start_det = scl_sync[1] & scl_sync[2] & sda_sync[2] & ~sda_sync[1];
  assign stop_det  = scl_sync[1] & scl_sync[2] & ~sda_sync[2] & sda_sync[1];
  assign shifting  = (state == ADDR) || (state == WR_PTR) || (state == WR_DATA);
  assign ptr_inc   = ptr + PW'(1);

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    tx_nxt      = tx;
    ptr_nxt     = ptr;
    oe_nxt      = sda_oe;
    busy_nxt    = busy;
    rw_nxt      = rw;
    strobe_nxt  = 1'b0;
    mem_we      = 1'b0;
    // Bus conditions override any bit edge seen in the same cycle
    if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 4'd0;
      oe_nxt      = 1'b0;
    end else if (stop_det) begin
      state_nxt = IDLE;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      if (scl_rise && shifting && bit_cnt != 4'd8) begin
        shreg_nxt   = {shreg[6:0], sda_s};
        bit_cnt_nxt = bit_cnt + 4'd1;
      end
      case (state)
        ADDR: if (scl_fall && bit_cnt == 4'd8) begin
          if (shreg[7:1] == SLAVE_ADDR) begin
            state_nxt = ADDR_ACK;
            oe_nxt    = 1'b1;
            busy_nxt  = 1'b1;
            rw_nxt    = shreg[0];
          end else begin
            state_nxt = IGNORE;
            oe_nxt    = 1'b0;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (rw) begin
            state_nxt   = RD_DATA;
            tx_nxt      = {mem[ptr][6:0], 1'b0};
            oe_nxt      = ~mem[ptr][7];
            bit_cnt_nxt = 4'd1;
          end else begin
            state_nxt   = WR_PTR;
            oe_nxt      = 1'b0;
            bit_cnt_nxt = 4'd0;
          end
        end
        WR_PTR: if (scl_fall && bit_cnt == 4'd8) begin
          ptr_nxt   = shreg[PW-1:0];
          oe_nxt    = 1'b1;
          state_nxt = WR_PTR_ACK;
        end
        WR_PTR_ACK, WR_ACK: if (scl_fall) begin
          oe_nxt      = 1'b0;
          state_nxt   = WR_DATA;
          bit_cnt_nxt = 4'd0;
        end
        WR_DATA: if (scl_fall && bit_cnt == 4'd8) begin
          mem_we     = 1'b1;
          ptr_nxt    = ptr_inc;
          strobe_nxt = 1'b1;
          oe_nxt     = 1'b1;
          state_nxt  = WR_ACK;
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            oe_nxt    = 1'b0;
            state_nxt = RD_ACK;
          end else begin
            oe_nxt      = ~tx[7];
            tx_nxt      = {tx[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
        RD_ACK: if (scl_rise) begin
          ptr_nxt = ptr_inc;
          if (!sda_s) begin
            tx_nxt      = mem[ptr_inc];
            bit_cnt_nxt = 4'd0;
            state_nxt   = RD_DATA;
          end else begin
            state_nxt = IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage boundary: control state registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      rw        <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      ptr       <= ptr_nxt;
      sda_oe    <= oe_nxt;
      busy      <= busy_nxt;
      wr_strobe <= strobe_nxt;
      rw        <= rw_nxt;
    end
  end

  always_ff @(posedge PCLK) begin
    shreg <= shreg_nxt;
    tx    <= tx_nxt;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[ptr] <= shreg;
    end
  end

  assign dbg_data           = mem[dbg_addr];
  assign bus.slv_scl_pad_o  = 1'b0;
  assign bus.slv_scl_pad_oe = 1'b0;
  assign bus.slv_sda_pad_o  = 1'b0;
  assign bus.slv_sda_pad_oe = sda_oe;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master against the slave responder.
module tb_i2c_slave_responder;
  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       busy, wr_strobe;
  logic [3:0] dbg_addr = 4'd0;
  logic [7:0] dbg_data;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  int         checks = 0, errors = 0;
  int         strobe_cycles = 0, oe_cycles = 0, busy_cycles = 0;
  int         base_s, base_oe, base_b;
  logic       ack;
  logic [7:0] rd;

  i2c_slave_responder_if bus ();

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.slv_sda_pad_oe;

  i2c_slave_responder #(.SLAVE_ADDR(7'h50), .MEM_DEPTH(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus), .busy(busy),
    .wr_strobe(wr_strobe), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (wr_strobe) strobe_cycles++;
    if (bus.slv_sda_pad_oe) oe_cycles++;
    if (busy) busy_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic mem_chk(input string tag, input logic [3:0] idx, input logic [7:0] exp);
    dbg_addr = idx;
    #1;
    chk(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; w(5); scl_m = 1'b1; w(10); sda_m = 1'b0; w(10); scl_m = 1'b0; w(5);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; w(5); scl_m = 1'b1; w(10); sda_m = 1'b1; w(10);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; w(5); scl_m = 1'b1; w(10); scl_m = 1'b0; w(5);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; w(5); scl_m = 1'b1; w(5); b = bus.sda_i; w(5); scl_m = 1'b0; w(5);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(a);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    send_bit(nack);
  endtask

  initial begin
    w(4);
    PRESET = 1'b0;
    w(2);
    chk("rst_oe", {31'd0, bus.slv_sda_pad_oe}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_strobe", {31'd0, wr_strobe}, 0);
    chk("rst_ptr", {28'd0, dut.ptr}, 0);
    chk("scl_oe_const", {31'd0, bus.slv_scl_pad_oe}, 0);
    chk("sda_o_const", {31'd0, bus.slv_sda_pad_o}, 0);
    mem_chk("rst_mem0", 4'd0, 8'h00);

    // Write 11,22,33 starting at register 2
    base_s = strobe_cycles;
    i2c_start();
    write_byte(8'hA0, ack); chk("wr_addr_ack", {31'd0, ack}, 0);
    chk("wr_busy", {31'd0, busy}, 1);
    write_byte(8'h02, ack); chk("wr_ptr_ack", {31'd0, ack}, 0);
    write_byte(8'h11, ack); chk("wr_d0_ack", {31'd0, ack}, 0);
    write_byte(8'h22, ack); chk("wr_d1_ack", {31'd0, ack}, 0);
    write_byte(8'h33, ack); chk("wr_d2_ack", {31'd0, ack}, 0);
    i2c_stop();
    w(5);
    chk("wr_busy_after_stop", {31'd0, busy}, 0);
    chk("wr_strobes", strobe_cycles - base_s, 3);
    mem_chk("wr_mem2", 4'd2, 8'h11);
    mem_chk("wr_mem3", 4'd3, 8'h22);
    mem_chk("wr_mem4", 4'd4, 8'h33);
    chk("wr_ptr", {28'd0, dut.ptr}, 5);

    // Pointer set then repeated START read of three bytes
    i2c_start();
    write_byte(8'hA0, ack); chk("rd_waddr_ack", {31'd0, ack}, 0);
    write_byte(8'h02, ack); chk("rd_wptr_ack", {31'd0, ack}, 0);
    i2c_start();
    write_byte(8'hA1, ack); chk("rd_raddr_ack", {31'd0, ack}, 0);
    read_byte(1'b0, rd); chk("rd_b0", {24'd0, rd}, 32'h11);
    read_byte(1'b0, rd); chk("rd_b1", {24'd0, rd}, 32'h22);
    read_byte(1'b1, rd); chk("rd_b2", {24'd0, rd}, 32'h33);
    w(2);
    chk("rd_release_after_nack", {31'd0, bus.slv_sda_pad_oe}, 0);
    i2c_stop();
    w(5);
    chk("rd_ptr", {28'd0, dut.ptr}, 5);

    // Foreign address: never drive, never busy
    base_oe = oe_cycles; base_b = busy_cycles; base_s = strobe_cycles;
    i2c_start();
    write_byte(8'hA2, ack); chk("mis_addr_nack", {31'd0, ack}, 1);
    write_byte(8'h55, ack); chk("mis_data_nack", {31'd0, ack}, 1);
    i2c_stop();
    w(5);
    chk("mis_oe_cycles", oe_cycles - base_oe, 0);
    chk("mis_busy_cycles", busy_cycles - base_b, 0);
    chk("mis_strobes", strobe_cycles - base_s, 0);
    mem_chk("mis_mem2", 4'd2, 8'h11);
    chk("mis_ptr", {28'd0, dut.ptr}, 5);

    // Pointer 0x1F truncates to 15, data wraps to 0
    i2c_start();
    write_byte(8'hA0, ack); chk("wrap_addr_ack", {31'd0, ack}, 0);
    write_byte(8'h1F, ack); chk("wrap_ptr_ack", {31'd0, ack}, 0);
    write_byte(8'hAA, ack);
    write_byte(8'hBB, ack);
    i2c_stop();
    w(5);
    mem_chk("wrap_mem15", 4'd15, 8'hAA);
    mem_chk("wrap_mem0", 4'd0, 8'hBB);
    chk("wrap_ptr", {28'd0, dut.ptr}, 1);

    // STOP after four bits of a data byte
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h07, ack); chk("part_ptr_ack", {31'd0, ack}, 0);
    base_s = strobe_cycles;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    w(5);
    chk("part_strobes", strobe_cycles - base_s, 0);
    mem_chk("part_mem7", 4'd7, 8'h00);
    chk("part_ptr", {28'd0, dut.ptr}, 7);
    chk("part_busy", {31'd0, busy}, 0);

    // Reset while the slave drives the ACK of a read address
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b1 : ((8'hA0 >> i) & 1'b1) != 0);
    sda_m = 1'b1; w(5);
    chk("rst_ack_driven", {31'd0, bus.slv_sda_pad_oe}, 1);
    #2 PRESET = 1'b1;
    #1 chk("rst_async_release", {31'd0, bus.slv_sda_pad_oe}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_ptr", {28'd0, dut.ptr}, 0);
    mem_chk("rst_mid_mem2", 4'd2, 8'h00);
    mem_chk("rst_mid_mem15", 4'd15, 8'h00);
    w(3);
    PRESET = 1'b0;
    w(5); scl_m = 1'b1; w(20);

    i2c_start();
    write_byte(8'hA0, ack); chk("post_addr_ack", {31'd0, ack}, 0);
    write_byte(8'h03, ack);
    write_byte(8'h5A, ack); chk("post_data_ack", {31'd0, ack}, 0);
    i2c_stop();
    w(5);
    mem_chk("post_mem3", 4'd3, 8'h5A);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h03, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    read_byte(1'b1, rd); chk("post_read", {24'd0, rd}, 32'h5A);
    i2c_stop();
    w(5);
    chk("post_ptr", {28'd0, dut.ptr}, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
